bcd_digit_converter: RTL
========================

Name: bcd_digit_converter

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one shift per clock.
- Sits directly upstream of the per-digit seven-segment decoders.
- Accepts one unsigned binary value through a valid/ready handshake and produces NUM_DIGITS decimal digit lanes, each 5 bits wide, which wire straight into the 5-bit decoder inputs.
- Flags values that do not fit in the display and drives an error code on every lane.

Parameters:
- DATA_W, 16, width of the unsigned binary input.
- NUM_DIGITS, 4, number of displayed decimal digits / output lanes.
- ERR_CODE, 5'h1F, lane value driven on overflow; it falls into the decoders' default (error) pattern.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  converter can accept a value; high only in IDLE.
- in_data  input  DATA_W  unsigned binary value to convert.
- digits_o  output  NUM_DIGITS*5  digit lanes. Lane i occupies bits [5i+4:5i]; lane 0 is the least significant digit. Each lane carries 0..9 with bit 4 = 0, or ERR_CODE.
- overflow  output  1  the last completed conversion exceeded 10^NUM_DIGITS-1.
- done  output  1  one-cycle pulse marking the cycle in which digits_o and overflow update.

Behaviour:
- Reset (synchronous, active-high, clk and rst only): state=IDLE, digits_o=0 (all lanes 0), overflow=0, done=0, in_ready=1. Reset mid-conversion discards the conversion with no output update.
- Internal width: localparam INT_DIGITS = (DATA_W*301)/1000 + 1. This gives enough BCD digits for 2^DATA_W-1; with the defaults it is 5.
- Working register = {bcd[INT_DIGITS*4], bin[DATA_W]}; bit counter is clog2(DATA_W+1) bits.
- State machine (IDLE, SHIFT, FINISH):
  - IDLE: in_ready=1. On in_valid at a rising edge: bcd<=0, bin<=in_data, count<=0, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle, every BCD nibble >=5 gets +3 (all nibbles corrected in parallel from the pre-shift value), then the whole register shifts left by 1 and count increments. Once DATA_W shifts are done, go to FINISH.
  - FINISH: latch the outputs and pulse done=1 for the following cycle, then go to IDLE.
- Output latch in FINISH:
  - If any BCD digit at index >= NUM_DIGITS is nonzero: overflow<=1 and every lane <= ERR_CODE.
  - Otherwise: overflow<=0 and lane i <= {1'b0, bcd digit i}.
- Latency: a value accepted at edge E produces updated digits_o, overflow and done=1 in the cycle after edge E+DATA_W+1 (17 cycles with the defaults).
- in_ready is high in the same cycle done is high. A value presented then is accepted, giving a back-to-back throughput of one value per DATA_W+2 cycles.
- digits_o and overflow hold their last value at all times, including during a new conversion, so the display never flickers.
- in_valid while in_ready=0 is ignored. There is no internal buffering; the upstream holds in_valid until in_ready.
- Boundary values:
  - in_data=0 gives all lanes 0 with no leading-zero blanking.
  - in_data=10^NUM_DIGITS-1 is the largest non-overflow value.
  - If INT_DIGITS <= NUM_DIGITS, overflow is constant 0.
- Arithmetic is unsigned only; no carry leaves the BCD field because INT_DIGITS covers the full input range.

Decomposition:
- Shared display package holds:
  - LANE_W=5 and ERR_CODE_DEFAULT=5'h1F;
  - the state enum {IDLE, SHIFT, FINISH};
  - a function for the INT_DIGITS calculation.
- One natural sub-module: bcd_add3_nibble, the combinational nibble correction (>=5 → +3), instantiated INT_DIGITS times.

Test Plan:
- rst high 2 cycles, then low → digits_o=0, overflow=0, done=0, in_ready=1.
- in_data=1234 with in_valid for 1 cycle → done after 17 cycles; lanes 3..0 = 1,2,3,4; overflow=0; in_ready low throughout the conversion.
- in_data=9999, then separately 0 → lanes 9,9,9,9 with overflow=0; then lanes 0,0,0,0.
- in_data=10000, then 65535 → every lane 5'h1F, overflow=1 both times; a following 42 → lanes 0,0,4,2 with overflow=0.
- in_valid held high with 42, then 7 presented in the done cycle → 7 accepted in that cycle; second done 18 cycles after the first; digits_o shows 0042 until the second done.
- Start 1234, assert rst for 1 cycle at the 5th SHIFT cycle → no done pulse, digits_o=0, in_ready=1 in the next cycle; a following 56 converts normally.

Source files
------------

// File: rtl/bcd_digit_converter_pkg.sv
// bcd_digit_converter_pkg: shared display constants, converter states and BCD sizing helper
package bcd_digit_converter_pkg;
  localparam int LANE_W = 5;
  localparam logic [LANE_W-1:0] ERR_CODE_DEFAULT = 5'h1F;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  function automatic int int_digits(input int w);
    return (w * 301) / 1000 + 1;
  endfunction
endpackage

// File: rtl/bcd_add3_nibble.sv
// bcd_add3_nibble: double-dabble digit correction, adds 3 to a nibble of 5 or more
module bcd_add3_nibble (
  input  logic [3:0] d,
  output logic [3:0] q
);
  // pre-shift correction so the following left shift carries into the next decade
  always_comb q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/bcd_digit_converter.sv
// bcd_digit_converter: sequential shift-and-add-3 binary to BCD converter feeding 5-bit digit lanes
module bcd_digit_converter
  import bcd_digit_converter_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                NUM_DIGITS = 4,
  parameter logic [LANE_W-1:0] ERR_CODE   = ERR_CODE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic [NUM_DIGITS*LANE_W-1:0] digits_o,
  output logic                         overflow,
  output logic                         done
);
  localparam int INT_DIGITS = int_digits(DATA_W);
  localparam int BCD_W      = INT_DIGITS * 4;
  localparam int WORK_W     = BCD_W + DATA_W;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  state_t                       state, state_nxt;
  logic [WORK_W-1:0]            work, corr;
  logic [CNT_W-1:0]             count;
  logic                         last_shift, hi_nz;
  logic [NUM_DIGITS*LANE_W-1:0] lanes;
  for (genvar i = 0; i < INT_DIGITS; i++) begin : g_corr
    bcd_add3_nibble u_add3 (
      .d(work[DATA_W+4*i +: 4]),
      .q(corr[DATA_W+4*i +: 4])
    );
  end
  assign corr[DATA_W-1:0] = work[DATA_W-1:0];
  assign last_shift = count == CNT_W'(DATA_W - 1);
  if (INT_DIGITS > NUM_DIGITS) begin : g_ovf
    assign hi_nz = |work[WORK_W-1:DATA_W+NUM_DIGITS*4];
  end else begin : g_no_ovf
    assign hi_nz = 1'b0;
  end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    if (i < INT_DIGITS) begin : g_dig
      assign lanes[LANE_W*i +: LANE_W] = {1'b0, work[DATA_W+4*i +: 4]};
    end else begin : g_pad
      assign lanes[LANE_W*i +: LANE_W] = '0;
    end
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next state: accept in IDLE, DATA_W shift cycles, one cycle to latch outputs
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = FINISH;
      default: state_nxt = IDLE;
    endcase
  end
  // handshake output
  always_comb in_ready = state == IDLE;
  // datapath: load, correct-and-shift, then latch lanes; lanes hold between conversions
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      count    <= '0;
      digits_o <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= state == FINISH;
      if (state == IDLE && in_valid) begin
        work  <= {{BCD_W{1'b0}}, in_data};
        count <= '0;
      end else if (state == SHIFT) begin
        work  <= corr << 1;
        count <= count + CNT_W'(1);
      end
      if (state == FINISH) begin
        overflow <= hi_nz;
        digits_o <= hi_nz ? {NUM_DIGITS{ERR_CODE}} : lanes;
      end
    end
  end
endmodule
